// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared CPU word width, NOP encoding, PC step and IF/ID entry.
// Revision    : 1.0
// ============================================================================
package cpu_pkg;

    localparam int unsigned WORD_W = 32;
    localparam logic [WORD_W-1:0] NOP     = 32'h0000_0000;
    localparam logic [WORD_W-1:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] pc_plus4;
        logic [WORD_W-1:0] instr;
    } if_entry_t;

endpackage
`default_nettype wire

// File: rtl/queue_storage.sv
`default_nettype none
// ============================================================================
// Module      : queue_storage
// Description : DEPTH x DATA_W register array, one write port, async read port.
// Revision    : 1.0
// ============================================================================
module queue_storage #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned DATA_W = 96,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Contents are never reset; the top masks outputs with its own valid state.
    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule
`default_nettype wire

// File: rtl/if_id_queue.sv
`default_nettype none
// ============================================================================
// Module      : if_id_queue
// Description : Fetch-to-decode FIFO with flush; presents {pc, pc+4, instr}.
// Revision    : 1.0
// ============================================================================
module if_id_queue
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = WORD_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] pc_in,
    input  logic [WIDTH-1:0] instr_in,
    input  logic             fetch_valid,
    output logic             fetch_ready,
    input  logic             flush,
    output logic             id_valid,
    input  logic             id_ready,
    output logic [WIDTH-1:0] id_pc,
    output logic [WIDTH-1:0] id_pc_plus4,
    output logic [WIDTH-1:0] id_instr
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned ENTRY_W = 3 * WIDTH;
    localparam logic [CNT_W-1:0] C_FULL  = CNT_W'(DEPTH);
    localparam logic [WIDTH-1:0] C_NOP   = WIDTH'(NOP);
    localparam logic [WIDTH-1:0] C_STEP  = WIDTH'(PC_STEP);

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;
    logic               push, pop;
    logic [WIDTH-1:0]   pc_plus4;
    logic [ENTRY_W-1:0] wdata, rdata;

    // Full/empty come only from registered count: no id_ready -> fetch_ready path.
    assign fetch_ready = (count_q != C_FULL);
    assign id_valid    = (count_q != '0);
    assign push        = fetch_valid & fetch_ready & ~flush;
    assign pop         = id_valid & id_ready & ~flush;

    // Carry out of the adder is intentionally dropped (PC wraps modulo 2^WIDTH).
    assign pc_plus4 = pc_in + C_STEP;
    assign wdata    = {pc_in, pc_plus4, instr_in};

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    queue_storage #(
        .DEPTH  (DEPTH),
        .DATA_W (ENTRY_W),
        .ADDR_W (PTR_W)
    ) u_storage (
        .clock (clock),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (wdata),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

    assign id_pc       = id_valid ? rdata[ENTRY_W-1 -: WIDTH]   : '0;
    assign id_pc_plus4 = id_valid ? rdata[2*WIDTH-1 -: WIDTH]   : '0;
    assign id_instr    = id_valid ? rdata[WIDTH-1:0]            : C_NOP;

endmodule
`default_nettype wire

// File: tb/tb_if_id_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_id_queue
// Description : Directed bench for if_id_queue with a queue-based reference.
// Revision    : 1.0
// ============================================================================
module tb_if_id_queue;
    import cpu_pkg::*;

    localparam int unsigned DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in, instr_in;
    logic        fetch_valid, fetch_ready, flush;
    logic        id_valid, id_ready;
    logic [31:0] id_pc, id_pc_plus4, id_instr;

    int checks = 0;
    int errors = 0;

    if_id_queue #(.DEPTH(DEPTH), .WIDTH(32)) dut (
        .clock       (clk),
        .reset       (rst),
        .pc_in       (pc_in),
        .instr_in    (instr_in),
        .fetch_valid (fetch_valid),
        .fetch_ready (fetch_ready),
        .flush       (flush),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_pc       (id_pc),
        .id_pc_plus4 (id_pc_plus4),
        .id_instr    (id_instr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: an ordered list of accepted entries, bounded by DEPTH.
    if_entry_t model_q[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_q.delete();
        end else begin
            automatic bit do_pop  = !flush && id_ready && (model_q.size() != 0);
            automatic bit do_push = !flush && fetch_valid && (model_q.size() < DEPTH);
            automatic if_entry_t e;
            if (flush) begin
                model_q.delete();
            end else begin
                if (do_pop) void'(model_q.pop_front());
                if (do_push) begin
                    e.pc       = pc_in;
                    e.pc_plus4 = pc_in + 32'd4;
                    e.instr    = instr_in;
                    model_q.push_back(e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (model_q.size() != 0) begin
                check("cmp id_valid", {31'd0, id_valid}, 32'd1);
                check("cmp id_pc", id_pc, model_q[0].pc);
                check("cmp id_pc_plus4", id_pc_plus4, model_q[0].pc_plus4);
                check("cmp id_instr", id_instr, model_q[0].instr);
            end else begin
                check("cmp id_valid", {31'd0, id_valid}, 32'd0);
                check("cmp id_pc empty", id_pc, 32'd0);
                check("cmp id_pc_plus4 empty", id_pc_plus4, 32'd0);
                check("cmp id_instr empty", id_instr, NOP);
            end
            check("cmp fetch_ready", {31'd0, fetch_ready},
                  {31'd0, (model_q.size() != DEPTH)});
        end
    end

    // Drive inputs 2 time units after a rising edge, then advance one clock.
    task automatic cycle(input logic fv, input logic [31:0] pc, input logic [31:0] ins,
                         input logic rdy, input logic fl);
        fetch_valid = fv;
        pc_in       = pc;
        instr_in    = ins;
        id_ready    = rdy;
        flush       = fl;
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; fetch_valid = 1'b0; pc_in = '0; instr_in = '0;
        id_ready = 1'b0; flush = 1'b0;
        #1;
        check("reset id_valid", {31'd0, id_valid}, 32'd0);
        check("reset fetch_ready", {31'd0, fetch_ready}, 32'd1);
        check("reset id_pc", id_pc, 32'd0);
        check("reset id_instr", id_instr, 32'd0);
        @(posedge clk); #2;
        rst = 1'b0;

        // Streaming
        cycle(1, 32'h00, 32'hAAAA_0001, 1, 0);
        check("stream0 pc", id_pc, 32'h00);
        check("stream0 pc4", id_pc_plus4, 32'h04);
        check("stream0 instr", id_instr, 32'hAAAA_0001);
        cycle(1, 32'h04, 32'hBBBB_0002, 1, 0);
        check("stream1 pc4", id_pc_plus4, 32'h08);
        check("stream1 instr", id_instr, 32'hBBBB_0002);
        cycle(1, 32'h08, 32'hCCCC_0003, 1, 0);
        check("stream2 pc4", id_pc_plus4, 32'h0C);
        check("stream2 ready", {31'd0, fetch_ready}, 32'd1);
        cycle(0, 0, 0, 1, 0);
        check("stream drained", {31'd0, id_valid}, 32'd0);

        // Backpressure
        cycle(1, 32'h10, 32'hD000_0010, 0, 0);
        cycle(1, 32'h14, 32'hD000_0014, 0, 0);
        check("bp full", {31'd0, fetch_ready}, 32'd0);
        cycle(1, 32'h18, 32'hD000_0018, 0, 0);
        check("bp head", id_pc, 32'h10);
        cycle(0, 0, 0, 1, 0);
        check("bp pop1 pc", id_pc, 32'h14);
        check("bp ready back", {31'd0, fetch_ready}, 32'd1);
        cycle(0, 0, 0, 1, 0);
        check("bp empty", {31'd0, id_valid}, 32'd0);

        // Flush
        cycle(1, 32'h20, 32'hE000_0020, 0, 0);
        cycle(1, 32'h24, 32'hE000_0024, 0, 0);
        cycle(1, 32'h40, 32'hE000_0040, 0, 1);
        check("flush valid", {31'd0, id_valid}, 32'd0);
        check("flush ready", {31'd0, fetch_ready}, 32'd1);
        cycle(1, 32'h80, 32'hE000_0080, 0, 0);
        check("post flush head", id_pc, 32'h80);
        cycle(0, 0, 0, 1, 0);

        // Wrap of PC and pointers
        cycle(1, 32'hFFFF_FFFC, 32'h1234_5678, 0, 0);
        check("wrap pc4", id_pc_plus4, 32'h0000_0000);
        cycle(0, 0, 0, 1, 0);
        for (int i = 0; i < 10; i++) begin
            cycle(1, 32'h100 + 32'(4 * i), 32'hF000_0000 + 32'(i), 1, 0);
            check("wrap order", id_pc, 32'h100 + 32'(4 * i));
        end
        cycle(0, 0, 0, 1, 0);

        // Simultaneous push and pop at count=1
        cycle(1, 32'h1F0, 32'h9000_01F0, 0, 0);
        cycle(1, 32'h200, 32'h9000_0200, 1, 0);
        check("simul head", id_pc, 32'h200);
        check("simul ready", {31'd0, fetch_ready}, 32'd1);
        check("simul valid", {31'd0, id_valid}, 32'd1);

        // Asynchronous reset between edges with a live entry
        cycle(1, 32'h300, 32'h9000_0300, 0, 0);
        fetch_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("async rst valid", {31'd0, id_valid}, 32'd0);
        check("async rst ready", {31'd0, fetch_ready}, 32'd1);
        check("async rst instr", id_instr, 32'd0);
        rst = 1'b0;
        cycle(0, 0, 0, 1, 0);
        check("after rst empty", {31'd0, id_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
